// File: rtl/mitchell_antilog.sv
// mitchell_antilog
//
// Purpose:
//   Pipelined Mitchell antilogarithm converter. Takes a summed logarithm
//   (integer characteristic k plus fraction f) and rebuilds the binary
//   product ((2^FRAC_W + f) << k) >> FRAC_W. There are two registered stages
//   with valid/ready handshakes on both sides. The block runs at one beat per
//   cycle and holds up to two beats under backpressure.
//
// Parameters:
//   FRAC_W   fraction width (operand width - 1)
//   K_W      characteristic width; the output width is OUT_W = 2**K_W
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle (combinational from out_ready)
//   in_k       characteristic
//   in_f       fractional part of the log
//   in_zero    an operand was zero; forces the product to 0
//   out_valid  out_p holds a valid product
//   out_ready  consumer accepts the product this cycle
//   out_p      reconstructed product (registered)
//
// Configuration macro:
//   ANTILOG_ROUND_EN  when defined, adds half an LSB before the final right
//                     shift (round half-up) to reduce truncation bias.
//                     When undefined, the result is plainly truncated.
//                     Pipeline timing is the same in both builds.

module mitchell_antilog #(
  parameter int FRAC_W = 7,
  parameter int K_W    = 4,
  parameter int OUT_W  = 2 ** K_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K_W-1:0]    in_k,
  input  logic [FRAC_W-1:0] in_f,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_p
);

  // The shift runs at full width so the largest k never loses a mantissa bit.
  localparam int M_W  = FRAC_W + 1;
  localparam int WW   = M_W + OUT_W - 1;
  localparam int PAD  = WW - M_W;

`ifdef ANTILOG_ROUND_EN
  localparam logic [WW-1:0] ROUND = WW'(1) << (FRAC_W - 1);
`else
  localparam logic [WW-1:0] ROUND = '0;
`endif

  logic              s1_valid;
  logic              s1_zero;
  logic [K_W-1:0]    s1_k;
  logic [M_W-1:0]    s1_m;
  logic              s2_valid;

  logic              s1_adv;
  logic              s2_adv;
  logic [WW-1:0]     shifted;
  logic [WW-1:0]     biased;
  logic [OUT_W-1:0]  p_next;

  // A stage may advance when it is empty or its downstream is advancing.
  // This chain is the only combinational path from out_ready to in_ready.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  // Stage 2 datapath. The mantissa with its implicit leading one is shifted
  // by the characteristic. The optional rounding constant is added, then the
  // fraction bits are dropped. The wide width equals OUT_W + FRAC_W, so the
  // cast after the shift loses nothing.
  always_comb begin
    shifted = {{PAD{1'b0}}, s1_m} << s1_k;
    biased  = shifted + ROUND;
    p_next  = s1_zero ? '0 : OUT_W'(biased >> FRAC_W);
  end

  // Stage 1 captures a beat on handshake. It drops its valid when the beat
  // moves on and nothing replaces it. Data is left untouched while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_k     <= '0;
      s1_m     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_zero  <= in_zero;
      s1_k     <= in_k;
      s1_m     <= {1'b1, in_f};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 takes whatever stage 1 holds whenever it can advance. While the
  // consumer stalls, out_p and out_valid stay frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_p    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      out_p    <= p_next;
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_mitchell_antilog.sv
// tb_mitchell_antilog
//
// Self-checking bench for mitchell_antilog at default parameters
// (FRAC_W=7, K_W=4, OUT_W=16). Inputs change on the falling edge, and
// outputs are sampled 1 time unit later. Every value observed therefore
// reflects the state after the preceding rising edge. Expected values that
// differ between builds are selected by ANTILOG_ROUND_EN.

module tb_mitchell_antilog;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_k;
  logic [6:0]  in_f;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int tests = 0;
  int fails = 0;

  mitchell_antilog #(.FRAC_W(7), .K_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_k      (in_k),
    .in_f      (in_f),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  // Reference product computed as an integer product and divide.
  function automatic logic [15:0] ref_p(input int k, input int f, input bit z);
    longint num;
    if (z) return 16'd0;
    num = longint'(128 + f) * (longint'(1) << k);
`ifdef ANTILOG_ROUND_EN
    num = num + 64;
`endif
    return 16'(num / 128);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_k = '0; in_f = '0; in_zero = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++;
    if (out_p !== 16'd0) begin fails++; $display("[TB] FAIL reset_out_p: got %0d want 0", out_p); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // One isolated beat with the consumer always ready. Also checks that the
  // product shows up one edge after the accepting edge (two stages).
  task automatic send_one(input string name, input int k, input int f, input bit z,
                          input logic [15:0] exp);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_k = 4'(k); in_f = 7'(f); in_zero = z; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL %s_in_ready: got %b want 1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat !== 2) begin fails++; $display("[TB] FAIL %s_latency: got %0d edges want 2", name, lat); end
    tests++;
    if (out_p !== exp) begin fails++; $display("[TB] FAIL %s_value: got %0d want %0d", name, out_p, exp); end
  endtask

  task automatic test_directed();
`ifdef ANTILOG_ROUND_EN
    localparam logic [15:0] K0F100 = 16'd2;
`else
    localparam logic [15:0] K0F100 = 16'd1;
`endif
    send_one("k5_f0",    5,   0, 1'b0, 16'd32);
    send_one("k3_f64",   3,  64, 1'b0, 16'd12);
    send_one("k0_f100",  0, 100, 1'b0, K0F100);
    send_one("k15_f127", 15, 127, 1'b0, 16'd65280);
    send_one("zero",     15, 127, 1'b1, 16'd0);
  endtask

  // Three beats (products 1, 2, 4) offered while the consumer stalls.
  task automatic test_backpressure();
    logic [15:0] got[$];
    int          idx;
    bit          exp_ready[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp_out[3] = '{16'd1, 16'd2, 16'd4};
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = (idx < 3); in_k = 4'(idx); in_f = '0; in_zero = 1'b0;
      #1;
      tests++;
      if (in_ready !== exp_ready[cyc]) begin
        fails++; $display("[TB] FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, exp_ready[cyc]);
      end
      if (in_valid && in_ready) idx++;
    end
    tests++;
    if (idx !== 2) begin fails++; $display("[TB] FAIL bp_accepts: got %0d want 2", idx); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_p !== 16'd1) begin
        fails++; $display("[TB] FAIL bp_hold_c%0d: got valid=%b p=%0d want valid=1 p=1", cyc, out_valid, out_p);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (idx < 3); in_k = 4'(idx);
      #1;
      if (out_valid && out_ready) got.push_back(out_p);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (got.size() !== 3) begin fails++; $display("[TB] FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_out[i]) begin fails++; $display("[TB] FAIL bp_order_%0d: got %0d want %0d", i, got[i], exp_out[i]); end
    end
  endtask

  // 100% valid and ready: every cycle must accept, and after the first
  // product, every cycle must emit.
  task automatic test_back_to_back();
    int sent, recv, stalls, gaps;
    logic [15:0] exp[$];
    sent = 0; recv = 0; stalls = 0; gaps = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 20); in_k = 4'(sent % 16); in_f = 7'((sent * 37) % 128); in_zero = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (exp.size() == 0 || out_p !== exp[0]) begin
          fails++; $display("[TB] FAIL b2b_value_%0d: got %0d want %0d", recv, out_p, (exp.size() != 0) ? exp[0] : 16'hxxxx);
        end
        if (exp.size() != 0) void'(exp.pop_front());
        recv++;
      end else if (cyc >= 2 && cyc < 22) gaps++;
      if (in_valid) begin
        if (in_ready) begin
          exp.push_back(ref_p(sent % 16, (sent * 37) % 128, 1'b0));
          sent++;
        end else stalls++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (stalls !== 0) begin fails++; $display("[TB] FAIL b2b_stalls: got %0d want 0", stalls); end
    tests++;
    if (gaps !== 0) begin fails++; $display("[TB] FAIL b2b_gaps: got %0d want 0", gaps); end
    tests++;
    if (recv !== 20) begin fails++; $display("[TB] FAIL b2b_count: got %0d want 20", recv); end
  endtask

  task automatic test_random();
    logic [15:0] exp[$];
    int sent, recv, k, f, cyc;
    bit z;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10000 && cyc < 60000) begin
      @(negedge clk);
      k = int'($urandom_range(0, 15)); f = int'($urandom_range(0, 127));
      z = ($urandom_range(0, 15) == 0);
      in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_k = 4'(k); in_f = 7'(f); in_zero = z;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (exp.size() == 0) begin
          fails++; $display("[TB] FAIL rand_extra_%0d: got %0d want no beat", recv, out_p);
        end else begin
          if (out_p !== exp[0]) begin fails++; $display("[TB] FAIL rand_value_%0d: got %0d want %0d", recv, out_p, exp[0]); end
          void'(exp.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp.push_back(ref_p(k, f, z));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (recv !== 10000) begin fails++; $display("[TB] FAIL rand_count: got %0d want 10000", recv); end
    tests++;
    if (exp.size() !== 0) begin fails++; $display("[TB] FAIL rand_leftover: got %0d want 0", exp.size()); end
  endtask

  // Two beats in flight, then a one-cycle reset. Neither beat may appear.
  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_k = 4'(3 + i); in_f = '0; in_zero = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_full: got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_out_valid: got %b want 0", out_valid); end
    tests++;
    if (out_p !== 16'd0) begin fails++; $display("[TB] FAIL mid_out_p: got %0d want 0", out_p); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("[TB] FAIL mid_ghost: got %0d beats want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
